// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter: round-robin sharing of one register-file write port and two read ports
module regfile_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          rvalid,
  output logic [NUM_REQ*DATA_W-1:0]   rdata,
  output logic                        rf_we,
  output logic [ADDR_W-1:0]           rf_waddr,
  output logic [DATA_W-1:0]           rf_wdata,
  output logic [ADDR_W-1:0]           rf_raddr1,
  output logic [ADDR_W-1:0]           rf_raddr2,
  input  logic [DATA_W-1:0]           rf_rdata1,
  input  logic [DATA_W-1:0]           rf_rdata2
);
  localparam int PW = $clog2(NUM_REQ);
  logic [PW-1:0] wptr, rptr, wptr_nx, rptr_nx, wi, r1i, r2i;
  logic [NUM_REQ-1:0] wset, rset, wg, r1g, r2g;
  logic wh, r1h, r2h;
  function automatic logic [PW-1:0] wrap(input logic [PW-1:0] p, input int k);
    return PW'((int'(p) + k) % NUM_REQ);
  endfunction
  // requests are masked while in reset so no grant or write can leak out
  always_comb begin
    wset = req & req_we & {NUM_REQ{rst_n}};
    rset = req & ~req_we & {NUM_REQ{rst_n}};
    wh = 1'b0;
    r1h = 1'b0;
    r2h = 1'b0;
    wi = '0;
    r1i = '0;
    r2i = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!wh && wset[wrap(wptr, k)]) begin
        wh = 1'b1;
        wi = wrap(wptr, k);
      end
      if (rset[wrap(rptr, k)]) begin
        if (!r1h) begin
          r1h = 1'b1;
          r1i = wrap(rptr, k);
        end else if (!r2h) begin
          r2h = 1'b1;
          r2i = wrap(rptr, k);
        end
      end
    end
    wg = NUM_REQ'(wh) << wi;
    r1g = NUM_REQ'(r1h) << r1i;
    r2g = NUM_REQ'(r2h) << r2i;
    gnt = wg | r1g | r2g;
    rf_we = wh;
    rf_waddr = wh ? req_addr[wi*ADDR_W +: ADDR_W] : '0;
    rf_wdata = wh ? req_wdata[wi*DATA_W +: DATA_W] : '0;
    rf_raddr1 = r1h ? req_addr[r1i*ADDR_W +: ADDR_W] : '0;
    rf_raddr2 = r2h ? req_addr[r2i*ADDR_W +: ADDR_W] : '0;
    wptr_nx = wh ? wrap(wi, 1) : wptr;
    rptr_nx = r2h ? wrap(r2i, 1) : r1h ? wrap(r1i, 1) : rptr;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      rvalid <= '0;
      rdata <= '0;
    end else begin
      wptr <= wptr_nx;
      rptr <= rptr_nx;
      rvalid <= r1g | r2g;
      for (int i = 0; i < NUM_REQ; i++)
        if (r1g[i]) rdata[i*DATA_W +: DATA_W] <= rf_rdata1;
        else if (r2g[i]) rdata[i*DATA_W +: DATA_W] <= rf_rdata2;
    end
  end
endmodule
